// File: rtl/board_game_engine_if.sv
// Mouse cell-select bus between the cell mapper (master) and the game engine (slave).
// RW mirrors the engine's row/column index width for the same N.
interface board_game_engine_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned RW = ($clog2(N) < 1) ? 1 : $clog2(N);

  logic          sel_valid;
  logic [RW-1:0] sel_row;
  logic [RW-1:0] sel_col;

  modport master (output sel_valid, sel_row, sel_col);
  modport slave  (input  sel_valid, sel_row, sel_col);
endinterface

// File: rtl/board_game_engine.sv
// NxN, K-in-a-row X/O engine: board storage, cursor, turn control and a one-cell-per-cycle checker.
// Optional macro CURSOR_WRAP_EN: cursor wraps at board edges instead of saturating.
module board_game_engine #(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned RW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic                 CLK_100MHZ,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic                 place,
  input  logic                 new_game,
  board_game_engine_if.slave   sel_if,
  output logic [RW-1:0]        cursor_row,
  output logic [RW-1:0]        cursor_col,
  output logic [2*N*N-1:0]     board,
  output logic                 turn,
  output logic [1:0]           game_state,
  output logic                 busy,
  output logic                 illegal
);

  localparam int NI = int'(N);
  localparam int unsigned MW = $clog2(N * N + 1);
  localparam logic [RW-1:0] MaxIdx   = RW'(N - 1);
  localparam logic [3:0]    StepMax  = 4'(K - 1);
  localparam logic [4:0]    CntWin   = 5'(K);
  localparam logic [MW-1:0] CellsAll = MW'(N * N);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  // Button conditioning: 2-FF synchroniser plus rising-edge detector
  logic [5:0] btn, sync1_q, sync2_q, prev_q, rise;
  logic       up_e, down_e, left_e, right_e, place_e, ng_e;

  assign btn     = {new_game, place, right, left, down, up};
  assign rise    = sync2_q & ~prev_q;
  assign up_e    = rise[0];
  assign down_e  = rise[1];
  assign left_e  = rise[2];
  assign right_e = rise[3];
  assign place_e = rise[4];
  assign ng_e    = rise[5];

  state_e            state_q, state_d;
  logic [RW-1:0]     cur_r_q, cur_r_d, cur_c_q, cur_c_d;
  logic [2*N*N-1:0]  board_q, board_d;
  logic              turn_q, turn_d;
  logic [1:0]        gs_q, gs_d;
  logic              illegal_q, illegal_d;
  logic [MW-1:0]     mc_q, mc_d;
  logic [RW-1:0]     pl_r_q, pl_r_d, pl_c_q, pl_c_d;
  logic [1:0]        mark_q, mark_d;
  logic [1:0]        dir_q, dir_d;
  logic              bwd_q, bwd_d;
  logic [3:0]        steps_q, steps_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RW-1:0]     walk_r_q, walk_r_d, walk_c_q, walk_c_d;

  function automatic logic [RW-1:0] idx_dec(input logic [RW-1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == '0) ? MaxIdx : v - 1'b1;
`else
    return (v == '0) ? '0 : v - 1'b1;
`endif
  endfunction

  function automatic logic [RW-1:0] idx_inc(input logic [RW-1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == MaxIdx) ? '0 : v + 1'b1;
`else
    return (v == MaxIdx) ? MaxIdx : v + 1'b1;
`endif
  endfunction

  // Cursor: an in-range mouse select beats any button move; one move per cycle
  logic sel_ok;
  assign sel_ok = sel_if.sel_valid && (int'(sel_if.sel_row) < NI) && (int'(sel_if.sel_col) < NI);

  always_comb begin
    cur_r_d = cur_r_q;
    cur_c_d = cur_c_q;
    if (sel_ok) begin
      cur_r_d = RW'(sel_if.sel_row);
      cur_c_d = RW'(sel_if.sel_col);
    end else if (up_e) begin
      cur_r_d = idx_dec(cur_r_q);
    end else if (down_e) begin
      cur_r_d = idx_inc(cur_r_q);
    end else if (left_e) begin
      cur_c_d = idx_dec(cur_c_q);
    end else if (right_e) begin
      cur_c_d = idx_inc(cur_c_q);
    end
  end

  // Checker probe: next cell along the current direction and whether the walk may step onto it
  int   dr, dc, nr, nc, nidx, pidx;
  logic in_rng, step_ok;

  assign pidx = 2 * (int'(cur_r_q) * NI + int'(cur_c_q));

  always_comb begin
    dr = 0;
    dc = 0;
    unique case (dir_q)
      2'd0:    dc = 1;
      2'd1:    dr = 1;
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (bwd_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr      = int'(walk_r_q) + dr;
    nc      = int'(walk_c_q) + dc;
    in_rng  = (nr >= 0) && (nr < NI) && (nc >= 0) && (nc < NI);
    nidx    = in_rng ? 2 * (nr * NI + nc) : 0;
    step_ok = in_rng && (steps_q < StepMax) && (board_q[nidx +: 2] == mark_q);
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    gs_d      = gs_q;
    illegal_d = 1'b0;
    mc_d      = mc_q;
    pl_r_d    = pl_r_q;
    pl_c_d    = pl_c_q;
    mark_d    = mark_q;
    dir_d     = dir_q;
    bwd_d     = bwd_q;
    steps_d   = steps_q;
    cnt_d     = cnt_q;
    walk_r_d  = walk_r_q;
    walk_c_d  = walk_c_q;

    if (ng_e) begin
      board_d = '0;
      mc_d    = '0;
      turn_d  = 1'b0;
      gs_d    = 2'b00;
      state_d = StPlay;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (place_e) begin
            if (board_q[pidx +: 2] == 2'b00) begin
              mark_d              = turn_q ? 2'b10 : 2'b01;
              board_d[pidx +: 2]  = turn_q ? 2'b10 : 2'b01;
              mc_d                = mc_q + 1'b1;
              pl_r_d              = cur_r_q;
              pl_c_d              = cur_c_q;
              walk_r_d            = cur_r_q;
              walk_c_d            = cur_c_q;
              dir_d               = 2'd0;
              bwd_d               = 1'b0;
              steps_d             = '0;
              cnt_d               = 5'd1;
              state_d             = StCheck;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        StCheck: begin
          illegal_d = place_e;
          if (step_ok) begin
            walk_r_d = RW'(nr);
            walk_c_d = RW'(nc);
            steps_d  = steps_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end else if (!bwd_q) begin
            bwd_d    = 1'b1;
            walk_r_d = pl_r_q;
            walk_c_d = pl_c_q;
            steps_d  = '0;
          end else if (cnt_q >= CntWin) begin
            gs_d    = mark_q;
            state_d = StOver;
          end else if (dir_q == 2'd3) begin
            if (mc_q == CellsAll) begin
              gs_d    = 2'b11;
              state_d = StOver;
            end else begin
              turn_d  = ~turn_q;
              state_d = StPlay;
            end
          end else begin
            dir_d    = dir_q + 1'b1;
            bwd_d    = 1'b0;
            walk_r_d = pl_r_q;
            walk_c_d = pl_c_q;
            steps_d  = '0;
            cnt_d    = 5'd1;
          end
        end
        StOver: illegal_d = place_e;
        default: state_d = StPlay;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      state_q   <= StPlay;
      cur_r_q   <= '0;
      cur_c_q   <= '0;
      board_q   <= '0;
      turn_q    <= 1'b0;
      gs_q      <= 2'b00;
      illegal_q <= 1'b0;
      mc_q      <= '0;
      pl_r_q    <= '0;
      pl_c_q    <= '0;
      mark_q    <= 2'b00;
      dir_q     <= 2'd0;
      bwd_q     <= 1'b0;
      steps_q   <= '0;
      cnt_q     <= '0;
      walk_r_q  <= '0;
      walk_c_q  <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cur_r_q   <= cur_r_d;
      cur_c_q   <= cur_c_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      gs_q      <= gs_d;
      illegal_q <= illegal_d;
      mc_q      <= mc_d;
      pl_r_q    <= pl_r_d;
      pl_c_q    <= pl_c_d;
      mark_q    <= mark_d;
      dir_q     <= dir_d;
      bwd_q     <= bwd_d;
      steps_q   <= steps_d;
      cnt_q     <= cnt_d;
      walk_r_q  <= walk_r_d;
      walk_c_q  <= walk_c_d;
    end
  end

  assign cursor_row = cur_r_q;
  assign cursor_col = cur_c_q;
  assign board      = board_q;
  assign turn       = turn_q;
  assign game_state = gs_q;
  assign busy       = (state_q == StCheck);
  assign illegal    = illegal_q;

endmodule
